// File: rtl/ysyx_24090013_ifetch_sram_if.sv
// Fetch-side bus between the IFU (master) and the instruction memory responder (slave),
// plus the loader write port used to preload the program image.
interface ysyx_24090013_ifetch_sram_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_wen;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_wen, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_wen, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_24090013_ifetch_sram.sv
// Instruction-memory responder: one outstanding word fetch, fixed latency, registered read,
// with a loader port that can write the array in any state.
module ysyx_24090013_ifetch_sram #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  ysyx_24090013_ifetch_sram_if.slave        bus
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Both bounds are checked so that addresses below BASE cannot wrap into the array.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr >= BASE) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return IDX_W'(off >> 2);
  endfunction

  function automatic logic req_bad(input logic [31:0] addr);
    return !in_range(addr) || (addr[1:0] != 2'b00);
  endfunction

  logic [31:0]      mem [DEPTH];

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [31:0]      rsp_data_q;
  logic             rsp_err_q;

  logic             req_fire;
  logic             capture;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_err;

  assign req_fire = rst && (state_q == IDLE) && bus.req_valid;

  // With LATENCY==1 the capture happens on the accept edge, so decode the live address.
  assign cap_idx  = (state_q == IDLE) ? word_idx(bus.req_addr) : idx_q;
  assign cap_err  = (state_q == IDLE) ? req_bad(bus.req_addr)  : err_q;
  assign capture  = (state_q != RESP) && (state_d == RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (capture) begin
        rsp_data_q <= cap_err ? 32'd0 : mem[cap_idx];
        rsp_err_q  <= cap_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          idx_d = word_idx(bus.req_addr);
          err_d = req_bad(bus.req_addr);
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready = rst;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

  // Loader writes use non-blocking update, so a same-edge capture reads the old word.
  always_ff @(posedge clk) begin
    if (rst && bus.ld_wen && in_range(bus.ld_addr)) begin
      mem[word_idx(bus.ld_addr)] <= bus.ld_data;
    end
  end

endmodule

// File: tb/tb_ysyx_24090013_ifetch_sram.sv
// Scoreboard bench: three responders with LATENCY 1, 3 and 2 exercised one at a time.
module tb_ysyx_24090013_ifetch_sram;

  localparam int N = 3;
  localparam int LATS [N] = '{1, 3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [N];
  logic [31:0] req_addr  [N];
  logic        rsp_ready [N];
  logic        ld_wen    [N];
  logic [31:0] ld_addr   [N];
  logic [31:0] ld_data   [N];
  logic        rdy       [N];
  logic        rv        [N];
  logic        rerr      [N];
  logic [31:0] rdata     [N];

  ysyx_24090013_ifetch_sram_if bus [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign bus[g].req_valid = req_valid[g];
    assign bus[g].req_addr  = req_addr[g];
    assign bus[g].rsp_ready = rsp_ready[g];
    assign bus[g].ld_wen    = ld_wen[g];
    assign bus[g].ld_addr   = ld_addr[g];
    assign bus[g].ld_data   = ld_data[g];
    assign rdy[g]   = bus[g].req_ready;
    assign rv[g]    = bus[g].rsp_valid;
    assign rerr[g]  = bus[g].rsp_err;
    assign rdata[g] = bus[g].rsp_data;

    ysyx_24090013_ifetch_sram #(
      .DEPTH  (1024),
      .BASE   (32'h8000_0000),
      .LATENCY(LATS[g])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb [$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation when rsp_valid rises; checks stability while it is held.
  logic prev_v [N];
  exp_t held   [N];
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) prev_v[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rv[i] === 1'b1) begin
          n_vec++;
          if (!prev_v[i]) begin
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL rsp_unexpected[%0d]: got data %h err %b at cycle %0d, want no response",
                       i, rdata[i], rerr[i], cyc);
              held[i].data = rdata[i];
              held[i].err  = rerr[i];
            end else begin
              e = sb.pop_front();
              held[i] = e;
              if (e.inst != i || rdata[i] !== e.data || rerr[i] !== e.err || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL rsp[%0d]: got data %h err %b cycle %0d, want inst %0d data %h err %b cycle %0d",
                         i, rdata[i], rerr[i], cyc, e.inst, e.data, e.err, e.cyc);
              end
            end
          end else if (rdata[i] !== held[i].data || rerr[i] !== held[i].err) begin
            n_fail++;
            $display("FAIL rsp_hold[%0d]: got data %h err %b, want data %h err %b",
                     i, rdata[i], rerr[i], held[i].data, held[i].err);
          end
        end
        prev_v[i] = (rv[i] === 1'b1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int i, input logic [31:0] addr, input logic [31:0] data);
    ld_wen[i]  = 1'b1;
    ld_addr[i] = addr;
    ld_data[i] = data;
    @(negedge clk);
    ld_wen[i]  = 1'b0;
  endtask

  // Presents a request and waits (bounded) for acceptance; optionally fires a loader
  // write to the same address in the accept cycle.
  task automatic issue(input int i, input logic [31:0] addr, input logic [31:0] d,
                       input logic e, input bit push, input bit ld,
                       input logic [31:0] ldd, output int acc);
    int   t;
    exp_t x;
    t = 0;
    acc = -1;
    req_valid[i] = 1'b1;
    req_addr[i]  = addr;
    while (rdy[i] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (rdy[i] !== 1'b1) begin
      n_vec++;
      n_fail++;
      $display("FAIL req_accept_timeout[%0d]: got req_ready %b after %0d cycles, want 1", i, rdy[i], t);
    end else begin
      acc = cyc;
      if (push) begin
        x.inst = i;
        x.data = d;
        x.err  = e;
        x.cyc  = cyc + LATS[i];
        sb.push_back(x);
      end
      if (ld) begin
        ld_wen[i]  = 1'b1;
        ld_addr[i] = addr;
        ld_data[i] = ldd;
      end
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    ld_wen[i]    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev_acc;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'd0;
      rsp_ready[i] = 1'b1;
      ld_wen[i]    = 1'b0;
      ld_addr[i]   = 32'd0;
      ld_data[i]   = 32'd0;
    end
    idle(2);

    // Reset: requests are refused and no response is produced.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h8000_0000;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_req_ready[%0d]", i), {31'd0, rdy[i]}, 32'd0);
      check($sformatf("reset_rsp_valid[%0d]", i), {31'd0, rv[i]}, 32'd0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("post_reset_req_ready[%0d]", i), {31'd0, rdy[i]}, 32'd1);
      check($sformatf("post_reset_rsp_valid[%0d]", i), {31'd0, rv[i]}, 32'd0);
      check($sformatf("post_reset_rsp_data[%0d]", i), rdata[i], 32'd0);
      check($sformatf("post_reset_rsp_err[%0d]", i), {31'd0, rerr[i]}, 32'd0);
    end

    // LATENCY=1 basic fetch.
    load(0, 32'h8000_0000, 32'h0000_0413);
    issue(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 1'b1, 1'b0, 32'd0, acc);
    idle(2);

    // Error decoding and boundary words; dropped loader writes must not alias.
    load(0, 32'h8000_0FFC, 32'hCAFE_F00D);
    load(0, 32'h7FFF_FFFC, 32'h0BAD_BAD0);
    load(0, 32'h8000_1000, 32'h0BAD_BAD1);
    load(0, 32'h8000_0009, 32'h2222_2222);
    issue(0, 32'h8000_0002, 32'd0,          1'b1, 1'b1, 1'b0, 32'd0, acc);
    issue(0, 32'h7FFF_FFFC, 32'd0,          1'b1, 1'b1, 1'b0, 32'd0, acc);
    issue(0, 32'h8000_1000, 32'd0,          1'b1, 1'b1, 1'b0, 32'd0, acc);
    issue(0, 32'h8000_0FFC, 32'hCAFE_F00D,  1'b0, 1'b1, 1'b0, 32'd0, acc);
    issue(0, 32'h8000_0008, 32'h2222_2222,  1'b0, 1'b1, 1'b0, 32'd0, acc);
    issue(0, 32'h8000_0000, 32'h0000_0413,  1'b0, 1'b1, 1'b0, 32'd0, acc);
    idle(2);

    // Read-old: loader write to idx 5 on the capture edge is not seen by that fetch.
    load(0, 32'h8000_0014, 32'h5555_5555);
    idle(2);
    issue(0, 32'h8000_0014, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, acc);
    idle(2);
    issue(0, 32'h8000_0014, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'd0, acc);
    idle(2);

    // LATENCY=3 with back-pressure: response held, no new request until release.
    load(1, 32'h8000_0004, 32'h0010_0093);
    rsp_ready[1] = 1'b0;
    issue(1, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'd0, acc);
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("busy_req_ready_c%0d", k), {31'd0, rdy[1]}, 32'd0);
      if (k == 6) rsp_ready[1] = 1'b1;
      @(negedge clk);
    end
    check("released_req_ready", {31'd0, rdy[1]}, 32'd1);
    check("released_rsp_valid", {31'd0, rv[1]}, 32'd0);
    check("released_rsp_data_hold", rdata[1], 32'h0010_0093);

    // Reset while in WAIT: request discarded, loader write during reset ignored.
    issue(1, 32'h8000_0004, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, acc);
    rst = 1'b0;
    ld_wen[1]  = 1'b1;
    ld_addr[1] = 32'h8000_0004;
    ld_data[1] = 32'h0000_0BAD;
    @(negedge clk);
    check("midreset_req_ready", {31'd0, rdy[1]}, 32'd0);
    check("midreset_rsp_valid", {31'd0, rv[1]}, 32'd0);
    ld_wen[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("after_midreset_req_ready", {31'd0, rdy[1]}, 32'd1);
    idle(6);
    issue(1, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'd0, acc);
    idle(5);

    // LATENCY=2 stream of 8 sequential PCs, accepted every 3 cycles.
    for (int k = 0; k < 8; k++) begin
      load(2, 32'h8000_0100 + 32'(4 * k), 32'h1000_0000 + 32'(k * 32'h11));
    end
    prev_acc = 0;
    for (int k = 0; k < 8; k++) begin
      issue(2, 32'h8000_0100 + 32'(4 * k), 32'h1000_0000 + 32'(k * 32'h11),
            1'b0, 1'b1, 1'b0, 32'd0, acc);
      if (k > 0) check($sformatf("stream_spacing_%0d", k), 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end
    idle(5);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
